itrx_apbm_arb: RTL and testbench

//  Round-robin arbiter and sequencer in front of itrx_apbm_fsm. Shares one APB master

---
 rtl/itrx_apbm_arb.sv | 206 ++++++++++++++++++++
 tb/tb_itrx_apbm_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/itrx_apbm_arb.sv
// Round-robin arbiter/sequencer sharing one APB master (itrx_apbm_fsm) between NUM_REQ requesters.
// Latches the winner's request, drives trans_start/assert_preset, returns ack/err/rdata, aborts hung slaves.
module itrx_apbm_arb #(
  parameter int unsigned             NUM_REQ     = 2,
  parameter int unsigned             ADDR_BITS_N = 5,
  parameter int unsigned             DATA_BITS_M = 8,
  parameter logic [ADDR_BITS_N-1:0]  RST_ADDR    = '1,
  parameter int unsigned             TIMEOUT     = 15
) (
  input  logic                             sclk,
  input  logic                             rst_n,
  input  logic                             pclk_re_e,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_BITS_N-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS_M-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               ack,
  output logic                             err,
  output logic [DATA_BITS_M-1:0]           rdata,
  output logic                             trans_start,
  output logic                             assert_preset,
  input  logic                             trans_done,
  input  logic                             pready,
  input  logic [DATA_BITS_M-1:0]           prdata,
  output logic [ADDR_BITS_N-1:0]           paddr,
  output logic [DATA_BITS_M-1:0]           pwdata,
  output logic                             pwrite
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  state_t                 r_state, w_nxt_state;
  logic [IDX_W-1:0]       r_last, w_nxt_last;
  logic [IDX_W-1:0]       r_owner, w_nxt_owner;
  logic [NUM_REQ-1:0]     r_gnt, w_nxt_gnt;
  logic [NUM_REQ-1:0]     r_ack, w_nxt_ack;
  logic                   r_err, w_nxt_err;
  logic [DATA_BITS_M-1:0] r_rdata, w_nxt_rdata;
  logic [ADDR_BITS_N-1:0] r_paddr, w_nxt_paddr;
  logic [DATA_BITS_M-1:0] r_pwdata, w_nxt_pwdata;
  logic                   r_pwrite, w_nxt_pwrite;
  logic                   r_tstart, w_nxt_tstart;
  logic                   r_preset, w_nxt_preset;
  logic [CNT_W-1:0]       r_cnt, w_nxt_cnt;

  logic                   w_any;
  logic [IDX_W-1:0]       w_win;
  logic [NUM_REQ-1:0]     w_win_gnt;
  logic [ADDR_BITS_N-1:0] w_win_addr;
  logic [DATA_BITS_M-1:0] w_win_wdata;
  logic                   w_win_write;

  // First requester at or after last_gnt+1 (mod NUM_REQ); lowest offset wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] rq,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    int unsigned      idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (32'(last) + 32'(k)) % NUM_REQ;
      cand = IDX_W'(idx);
      if (rq[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign w_any     = |req;
  assign w_win     = rr_pick(req, r_last);
  assign w_win_gnt = NUM_REQ'(1) << w_win;

  // Mux out the winning requester's payload.
  always_comb begin
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_win_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_win) begin
        w_win_addr  = req_addr[i*ADDR_BITS_N +: ADDR_BITS_N];
        w_win_wdata = req_wdata[i*DATA_BITS_M +: DATA_BITS_M];
        w_win_write = req_write[i];
      end
    end
  end

  // Next-state logic; everything except ack holds between pclk_re_e strobes.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_last   = r_last;
    w_nxt_owner  = r_owner;
    w_nxt_gnt    = r_gnt;
    w_nxt_ack    = '0;
    w_nxt_err    = r_err;
    w_nxt_rdata  = r_rdata;
    w_nxt_paddr  = r_paddr;
    w_nxt_pwdata = r_pwdata;
    w_nxt_pwrite = r_pwrite;
    w_nxt_tstart = r_tstart;
    w_nxt_preset = r_preset;
    w_nxt_cnt    = r_cnt;
    if (pclk_re_e) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            w_nxt_owner  = w_win;
            w_nxt_gnt    = w_win_gnt;
            w_nxt_paddr  = w_win_addr;
            w_nxt_pwdata = w_win_wdata;
            w_nxt_pwrite = w_win_write;
            w_nxt_tstart = 1'b1;
            w_nxt_preset = (w_win_addr == RST_ADDR);
            w_nxt_cnt    = '0;
            w_nxt_state  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          w_nxt_tstart = 1'b0;
          w_nxt_state  = ST_WAIT;
        end
        ST_WAIT: begin
          if (trans_done && (pready || r_preset)) begin
            if (!r_pwrite) w_nxt_rdata = prdata;
            w_nxt_ack    = r_gnt;
            w_nxt_err    = 1'b0;
            w_nxt_last   = r_owner;
            w_nxt_preset = 1'b0;
            w_nxt_gnt    = '0;
            w_nxt_state  = ST_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            // Preset forces the APB FSM out of ACCESS on a hung slave.
            w_nxt_preset = 1'b1;
            w_nxt_state  = ST_ABORT;
          end else if (r_cnt != '1) begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_ABORT: begin
          w_nxt_ack    = r_gnt;
          w_nxt_err    = 1'b1;
          w_nxt_last   = r_owner;
          w_nxt_preset = 1'b0;
          w_nxt_gnt    = '0;
          w_nxt_state  = ST_IDLE;
        end
        default: begin
          w_nxt_gnt    = '0;
          w_nxt_tstart = 1'b0;
          w_nxt_preset = 1'b0;
          w_nxt_state  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_owner  <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_tstart <= 1'b0;
      r_preset <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_last   <= w_nxt_last;
      r_owner  <= w_nxt_owner;
      r_gnt    <= w_nxt_gnt;
      r_ack    <= w_nxt_ack;
      r_err    <= w_nxt_err;
      r_rdata  <= w_nxt_rdata;
      r_paddr  <= w_nxt_paddr;
      r_pwdata <= w_nxt_pwdata;
      r_pwrite <= w_nxt_pwrite;
      r_tstart <= w_nxt_tstart;
      r_preset <= w_nxt_preset;
      r_cnt    <= w_nxt_cnt;
    end
  end

  assign gnt           = r_gnt;
  assign ack           = r_ack;
  assign err           = r_err;
  assign rdata         = r_rdata;
  assign trans_start   = r_tstart;
  assign assert_preset = r_preset;
  assign paddr         = r_paddr;
  assign pwdata        = r_pwdata;
  assign pwrite        = r_pwrite;

endmodule

// File: tb/tb_itrx_apbm_arb.sv
// Bench for itrx_apbm_arb: directed scenarios then random traffic against a transaction-level model.
module tb_itrx_apbm_arb;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;
  localparam logic [AW-1:0] RA = '1;

  logic             sclk, rst_n, pclk_re_e;
  logic [NR-1:0]    req, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt, ack;
  logic             err, trans_start, assert_preset, trans_done, pready, pwrite;
  logic [DW-1:0]    rdata, prdata, pwdata;
  logic [AW-1:0]    paddr;

  itrx_apbm_arb #(.NUM_REQ(NR), .ADDR_BITS_N(AW), .DATA_BITS_M(DW), .RST_ADDR(RA), .TIMEOUT(TO)) dut (
    .sclk(sclk), .rst_n(rst_n), .pclk_re_e(pclk_re_e),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .trans_start(trans_start), .assert_preset(assert_preset),
    .trans_done(trans_done), .pready(pready), .prdata(prdata),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Stand-in for the APB master FSM: IDLE -> SETUP -> ACCESS, slave ready after cur_d ACCESS strobes.
  int            apb_st, acc, cur_d;
  logic [DW-1:0] cur_pr;
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      apb_st <= 0;
      acc    <= 0;
    end else if (pclk_re_e) begin
      case (apb_st)
        0: if (trans_start) apb_st <= 1;
        1: begin apb_st <= 2; acc <= 0; end
        default: if (pready || assert_preset) apb_st <= 0; else acc <= acc + 1;
      endcase
    end
  end
  assign trans_done = (apb_st == 0) || (apb_st == 2);
  assign pready     = (apb_st == 2) && (acc >= cur_d);
  assign prdata     = cur_pr;

  int checks = 0, errors = 0;
  int s, xfers;
  bit m_busy, m_err, m_rst, m_wr, hold_mode, auto_mode;
  int m_own, m_g, m_acks, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdata;
  int            q_d [NR];
  logic [DW-1:0] q_pr [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (strobe %0d)", tag, obs, exp, s);
    end
  endtask

  task automatic raise(input int i, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic wr, input int d, input logic [DW-1:0] pr);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
    req_write[i]          = wr;
    q_d[i]                = d;
    q_pr[i]               = pr;
    req[i]                = 1'b1;
  endtask

  task automatic raise_rand(input int i);
    logic [AW-1:0] a;
    int r, d;
    a = ($urandom % 8 == 0) ? RA : AW'($urandom);
    r = int'($urandom % 16);
    d = (r < 10) ? r % 4 : (r < 12) ? 14 : (r < 14) ? 15 : 255;
    raise(i, a, DW'($urandom), 1'($urandom), d, DW'($urandom));
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = NR - 1; m_rdata = '0; m_err = 0; m_rst = 0;
  endtask

  // Called at each negedge: advance the model for the posedge just passed, check, then drive.
  task automatic step();
    logic [NR-1:0] e_ack, e_gnt;
    int idx;
    e_ack = '0;
    if (pclk_re_e) begin
      s++;
      if (m_busy) begin
        if (s == m_acks) begin
          e_ack  = NR'(1) << m_own;
          m_busy = 0;
          m_last = m_own;
          xfers++;
          if (!m_wr && !m_err) m_rdata = cur_pr;
        end
      end else if (req != '0) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (req[idx]) begin m_own = idx; break; end
        end
        m_busy = 1;
        m_g    = s;
        m_addr = req_addr[m_own*AW +: AW];
        m_wd   = req_wdata[m_own*DW +: DW];
        m_wr   = req_write[m_own];
        m_rst  = (m_addr == RA);
        if (m_rst || q_d[m_own] <= int'(TO) - 1) begin
          m_err  = 0;
          m_acks = s + 3 + (m_rst ? 0 : q_d[m_own]);
        end else begin
          m_err  = 1;
          m_acks = s + int'(TO) + 3;
        end
        cur_d  = q_d[m_own];
        cur_pr = q_pr[m_own];
      end
    end
    e_gnt = m_busy ? NR'(1) << m_own : '0;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("trans_start", 32'(trans_start), 32'(m_busy && s == m_g));
    chk("assert_preset", 32'(assert_preset),
        32'(m_busy && (m_rst || (m_err && s >= m_g + int'(TO) + 2))));
    if (e_ack != '0) chk("err", 32'(err), 32'(m_err));
    if (m_busy) begin
      chk("paddr", 32'(paddr), 32'(m_addr));
      chk("pwdata", 32'(pwdata), 32'(m_wd));
      chk("pwrite", 32'(pwrite), 32'(m_wr));
    end
    chk("rdata", 32'(rdata), 32'(m_rdata));
    for (int i = 0; i < NR; i++) begin
      if (e_ack[i]) begin
        req[i] = 1'b0;
        if (hold_mode) raise(i, AW'($urandom % 30), DW'($urandom), 1'($urandom), 0, DW'($urandom));
      end else if (auto_mode && !req[i] && ($urandom % 4 == 0)) begin
        raise_rand(i);
      end
    end
    pclk_re_e = ($urandom % 4 != 0);
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while ((req != '0 || m_busy) && n < bound) begin
      @(negedge sclk);
      step();
      n++;
    end
    checks++;
    assert (req == '0 && !m_busy) else begin
      errors++;
      $error("FAIL wait_idle: observed busy after %0d cycles, expected idle", bound);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_paddr"}, 32'(paddr), 0);
    chk({tag, "_pwdata"}, 32'(pwdata), 0);
    chk({tag, "_pwrite"}, 32'(pwrite), 0);
    chk({tag, "_trans_start"}, 32'(trans_start), 0);
    chk({tag, "_assert_preset"}, 32'(assert_preset), 0);
  endtask

  initial begin
    int n, target;
    rst_n = 1'b0; pclk_re_e = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    cur_d = 0; cur_pr = '0; s = 0; xfers = 0; hold_mode = 0; auto_mode = 0;
    m_own = 0; m_g = 0; m_acks = 0; m_wr = 0; m_addr = '0; m_wd = '0;
    for (int i = 0; i < NR; i++) begin q_d[i] = 0; q_pr[i] = '0; end
    model_reset();
    repeat (3) @(negedge sclk);
    check_all_zero("reset");
    rst_n = 1'b1; pclk_re_e = 1'b1;

    // Single write, slave ready at once.
    raise(0, 5'd3, 8'hA5, 1'b1, 0, 8'h00);
    run_until_idle(100);

    // Both requesting continuously: grants must alternate.
    hold_mode = 1;
    raise(0, 5'd1, 8'h10, 1'b1, 0, 8'h00);
    raise(1, 5'd2, 8'h20, 1'b0, 0, 8'h99);
    target = xfers + 4;
    n = 0;
    while (xfers < target && n < 400) begin @(negedge sclk); step(); n++; end
    checks++;
    assert (xfers >= target) else begin
      errors++;
      $error("FAIL rr_xfers: observed %0d transfers, expected %0d", xfers, target);
    end
    hold_mode = 0;
    run_until_idle(200);

    // Read with a slow slave.
    raise(1, 5'd7, 8'h00, 1'b0, 3, 8'h3C);
    run_until_idle(100);

    // Hung slave: timeout abort, then a normal transfer.
    raise(0, 5'd9, 8'h5A, 1'b1, 255, 8'h00);
    run_until_idle(300);
    raise(1, 5'd2, 8'h00, 1'b0, 1, 8'hC3);
    run_until_idle(100);

    // Reset-address read completes without pready.
    raise(0, RA, 8'h00, 1'b0, 255, 8'h77);
    run_until_idle(100);

    // Asynchronous reset in the middle of WAIT.
    raise(0, 5'd4, 8'h11, 1'b1, 255, 8'h00);
    n = 0;
    while (!(m_busy && s >= m_g + 5) && n < 200) begin @(negedge sclk); step(); n++; end
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    req = '0;
    model_reset();
    repeat (3) @(negedge sclk);
    chk("reset_hold_ack", 32'(ack), 0);
    rst_n = 1'b1; pclk_re_e = 1'b1;
    raise(0, 5'd5, 8'h66, 1'b1, 0, 8'h00);
    raise(1, 5'd6, 8'h00, 1'b0, 0, 8'h42);
    run_until_idle(200);

    // Random traffic.
    auto_mode = 1;
    repeat (4000) begin @(negedge sclk); step(); end
    auto_mode = 0;
    run_until_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
